// File: rtl/dac_stream.sv
// dac_stream: buffers PCM samples in a FIFO and serialises them left-justified, MSB-first onto DACDAT
module dac_stream #(
    parameter int N         = 16,
    parameter int DEPTH     = 4,
    parameter bit DUP_RIGHT = 1'b1
) (
    input  logic         bclk,
    input  logic         rst_n,
    input  logic         daclrc,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic [N-1:0] sample_data,
    output logic         dacdat,
    output logic         underrun,
    output logic [15:0]  underrun_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAD   = 2'd2;
    localparam logic [FW-1:0] FULL   = FW'(DEPTH);
    localparam logic [CW-1:0] NBITS  = CW'(N);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] count;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sr, hold_reg, word;
    logic          daclrc_q, rise, fall, empty, push, pop, start;

    assign rise         = daclrc & ~daclrc_q;
    assign fall         = ~daclrc & daclrc_q;
    assign empty        = count == '0;
    assign sample_ready = count != FULL;
    assign push         = sample_valid & sample_ready;
    assign pop          = rise & ~empty;
    // a fall only starts a frame once the first rise has taken us out of IDLE
    assign start        = rise | (fall & (state != IDLE));
    // left frame takes the FIFO head (zero on underrun); right frame repeats it or sends zero
    assign word         = rise ? (empty ? '0 : mem[rd_ptr]) : (DUP_RIGHT ? hold_reg : '0);

    // FIFO storage, data only
    always_ff @(posedge bclk)
        if (push) mem[wr_ptr] <= sample_data;

    // FIFO pointers and occupancy
    always_ff @(posedge bclk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + FW'(push) - FW'(pop);
        end

    // LRC edge history, right-channel copy and underrun reporting
    always_ff @(posedge bclk or negedge rst_n)
        if (!rst_n) begin
            daclrc_q       <= 1'b1;
            hold_reg       <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            daclrc_q <= daclrc;
            underrun <= rise & empty;
            if (rise) hold_reg <= word;
            if (rise & empty & ~&underrun_count) underrun_count <= underrun_count + 16'd1;
        end

    // serialiser: MSB goes out at the detection edge, remaining bits follow, then pad with zeros
    always_ff @(posedge bclk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            dacdat <= 1'b0;
        end else if (start) begin
            state  <= SHIFT;
            dacdat <= word[N-1];
            sr     <= word << 1;
            cnt    <= CW'(1);
        end else if (state == SHIFT) begin
            if (cnt == NBITS) begin
                state  <= PAD;
                dacdat <= 1'b0;
            end else begin
                dacdat <= sr[N-1];
                sr     <= sr << 1;
                cnt    <= cnt + CW'(1);
            end
        end
endmodule

// File: tb/tb_dac_stream.sv
// tb_dac_stream: scoreboard bench comparing both DUP_RIGHT variants against a frame-level model
module tb_dac_stream;
    localparam int N = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        d;
        logic        d0;
        logic        u;
        logic [15:0] c;
    } exp_t;

    logic bclk = 1'b0, rst_n = 1'b0, daclrc = 1'b1, sample_valid = 1'b0;
    logic [N-1:0] sample_data = '0;
    logic sample_ready, dacdat, underrun, sample_ready0, dacdat0, underrun0;
    logic [15:0] underrun_count, underrun_count0;

    int checks = 0, errors = 0;
    exp_t expq[$];
    logic [N-1:0] mq[$];
    logic [N-1:0] pend[$];
    logic [N-1:0] word = '0, word0 = '0, hold = '0;
    logic lvl_prev = 1'b1, started = 1'b0;
    int pos = N;
    logic [15:0] ucnt = '0;

    always #5 bclk = ~bclk;

    dac_stream #(.N(N), .DEPTH(DEPTH), .DUP_RIGHT(1'b1)) dut (
        .bclk(bclk), .rst_n(rst_n), .daclrc(daclrc), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_data(sample_data), .dacdat(dacdat),
        .underrun(underrun), .underrun_count(underrun_count));

    dac_stream #(.N(N), .DEPTH(DEPTH), .DUP_RIGHT(1'b0)) dut0 (
        .bclk(bclk), .rst_n(rst_n), .daclrc(daclrc), .sample_valid(sample_valid),
        .sample_ready(sample_ready0), .sample_data(sample_data), .dacdat(dacdat0),
        .underrun(underrun0), .underrun_count(underrun_count0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: every posedge that has an expectation queued is compared just after the edge
    initial forever begin
        @(posedge bclk);
        #1;
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("dacdat", dacdat, e.d);
            chk("dacdat_dup0", dacdat0, e.d0);
            chk("underrun", underrun, e.u);
            chk("underrun_dup0", underrun0, e.u);
            chk("underrun_count", underrun_count, e.c);
            chk("underrun_count_dup0", underrun_count0, e.c);
        end
    end

    // one bclk period: drive inputs at the negedge and queue what the next posedge must produce
    task automatic cycle(input logic lvl);
        logic r, f, rdy, emp, u;
        @(negedge bclk);
        rdy = mq.size() < DEPTH;
        emp = mq.size() == 0;
        chk("sample_ready", sample_ready, rdy);
        chk("sample_ready_dup0", sample_ready0, rdy);
        r = lvl & ~lvl_prev;
        f = ~lvl & lvl_prev;
        lvl_prev = lvl;
        u = 1'b0;
        daclrc = lvl;
        sample_valid = pend.size() != 0;
        sample_data = sample_valid ? pend[0] : N'($urandom);
        if (r) begin
            u = emp;
            word = emp ? '0 : mq.pop_front();
            word0 = word;
            hold = word;
            pos = 0;
            started = 1'b1;
            if (emp && ucnt != 16'hFFFF) ucnt++;
        end else if (f && started) begin
            word = hold;
            word0 = '0;
            pos = 0;
        end else begin
            pos++;
        end
        if (sample_valid && rdy) mq.push_back(pend.pop_front());
        expq.push_back('{pos < N ? word[N-1-pos] : 1'b0, pos < N ? word0[N-1-pos] : 1'b0, u, ucnt});
    endtask

    task automatic half(input logic lvl, input int len);
        repeat (len) cycle(lvl);
    endtask

    // asynchronous reset pulse placed between edges, with daclrc parked high
    task automatic do_reset();
        @(negedge bclk);
        sample_valid = 1'b0;
        daclrc = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_dacdat", dacdat, 1'b0);
        chk("reset_dacdat_dup0", dacdat0, 1'b0);
        chk("reset_ready", sample_ready, 1'b1);
        chk("reset_underrun", underrun, 1'b0);
        chk("reset_count", underrun_count, 16'h0);
        rst_n = 1'b1;
        mq.delete();
        pend.delete();
        started = 1'b0;
        pos = N;
        ucnt = '0;
        hold = '0;
        word = '0;
        word0 = '0;
        lvl_prev = 1'b1;
    endtask

    initial begin
        logic lvl;
        do_reset();
        // held high out of reset: nothing is sent
        pend.push_back(16'hA5C3);
        half(1, 6);
        half(0, 32);
        // basic left frame, then the duplicated right frame
        half(1, 32);
        pend.push_back(16'h1111);
        pend.push_back(16'h2222);
        pend.push_back(16'h3333);
        pend.push_back(16'h4444);
        pend.push_back(16'h5555);
        half(0, 32);
        // drain the FIFO in order, then underrun with it empty
        repeat (6) begin
            half(1, 32);
            half(0, 32);
        end
        // push into an empty FIFO on the same edge as the rise
        pend.push_back(16'h0001);
        half(1, 32);
        half(0, 32);
        half(1, 32);
        // short left frame cut by an early fall
        pend.push_back(16'h8E71);
        half(0, 32);
        half(1, 8);
        half(0, 32);
        // reset in the middle of a shifting frame
        pend.push_back(16'hC0DE);
        pend.push_back(16'hF00D);
        half(1, 32);
        half(0, 32);
        half(1, 5);
        do_reset();
        half(1, 4);
        half(0, 4);
        // random traffic with random frame lengths, including truncated frames
        lvl = 1'b1;
        repeat (60) begin
            if (lvl) repeat ($urandom_range(0, 2)) pend.push_back(N'($urandom));
            half(lvl, $urandom_range(6, 40));
            lvl = ~lvl;
        end
        @(negedge bclk);
        @(negedge bclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
